// File: rtl/screen_scanout.sv
// Frame-buffer scan-out for the Hack SCREEN region: fetches each 16-bit word
// and serialises it LSB-first as pixels under a valid/ready handshake.
module screen_scanout #(
   parameter logic [14:0] BASE_ADDR     = 15'd16384,
   parameter int          WORDS_PER_ROW = 32,
   parameter int          ROWS          = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   output logic [14:0] mem_address,
   input  logic [15:0] mem_out,
   output logic        pixel,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic        row_start,
   output logic        frame_done,
   output logic        busy
);

   localparam logic [12:0] LAST_WORD = 13'(WORDS_PER_ROW * ROWS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_r;
   logic [12:0] word_cnt_r;
   logic [3:0]  bit_cnt_r;
   logic [15:0] shift_r;
   logic [14:0] mem_address_r;
   logic        pixel_valid_r;
   logic        row_start_r;
   logic        frame_done_r;
   logic        busy_r;

   logic [12:0] word_inc_s;
   logic        last_word_s;
   logic        accept_s;
   logic        row_head_s;

   // Handshake and word-position decode
   always_comb begin
      word_inc_s  = word_cnt_r + 13'd1;
      last_word_s = (word_cnt_r == LAST_WORD);
      accept_s    = pixel_valid_r & pixel_ready;
      row_head_s  = ((int'(word_cnt_r) % WORDS_PER_ROW) == 0);
   end

   // Scan-out FSM with all outputs held in registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         word_cnt_r    <= 13'd0;
         bit_cnt_r     <= 4'd0;
         shift_r       <= 16'd0;
         mem_address_r <= BASE_ADDR;
         pixel_valid_r <= 1'b0;
         row_start_r   <= 1'b0;
         frame_done_r  <= 1'b0;
         busy_r        <= 1'b0;
      end else if (abort) begin
         // Cancel wins over start and over a completing handshake
         state_r       <= IDLE;
         word_cnt_r    <= 13'd0;
         bit_cnt_r     <= 4'd0;
         shift_r       <= 16'd0;
         mem_address_r <= BASE_ADDR;
         pixel_valid_r <= 1'b0;
         row_start_r   <= 1'b0;
         frame_done_r  <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               frame_done_r  <= 1'b0;
               mem_address_r <= BASE_ADDR;
               if (start) begin
                  state_r    <= FETCH;
                  word_cnt_r <= 13'd0;
                  busy_r     <= 1'b1;
               end
            end
            FETCH: begin
               shift_r       <= mem_out;
               bit_cnt_r     <= 4'd0;
               pixel_valid_r <= 1'b1;
               row_start_r   <= row_head_s;
               state_r       <= SHIFT;
            end
            SHIFT: begin
               if (accept_s) begin
                  shift_r     <= {1'b0, shift_r[15:1]};
                  bit_cnt_r   <= bit_cnt_r + 4'd1;
                  row_start_r <= 1'b0;
                  if (bit_cnt_r == 4'd15) begin
                     pixel_valid_r <= 1'b0;
                     if (last_word_s) begin
                        state_r       <= DONE;
                        frame_done_r  <= 1'b1;
                        word_cnt_r    <= 13'd0;
                        mem_address_r <= BASE_ADDR;
                     end else begin
                        state_r       <= FETCH;
                        word_cnt_r    <= word_inc_s;
                        mem_address_r <= BASE_ADDR + {2'b00, word_inc_s};
                     end
                  end
               end
            end
            DONE: begin
               frame_done_r <= 1'b0;
               busy_r       <= 1'b0;
               state_r      <= IDLE;
            end
            default: begin
               state_r       <= IDLE;
               word_cnt_r    <= 13'd0;
               bit_cnt_r     <= 4'd0;
               shift_r       <= 16'd0;
               mem_address_r <= BASE_ADDR;
               pixel_valid_r <= 1'b0;
               row_start_r   <= 1'b0;
               frame_done_r  <= 1'b0;
               busy_r        <= 1'b0;
            end
         endcase
      end
   end

   // Shifted-out bits are zero, so bit 0 reads 0 whenever no pixel is offered
   assign pixel       = shift_r[0];
   assign mem_address = mem_address_r;
   assign pixel_valid = pixel_valid_r;
   assign row_start   = row_start_r;
   assign frame_done  = frame_done_r;
   assign busy        = busy_r;

endmodule
